// File: rtl/uart_cmd_parser.sv
// Decodes "R<AAAAAA><LL><CR>" (hex, any case) from uart_rx into a window-checked flash read command.
// Define UART_CMD_ECHO_EN to echo every consumed byte (and '?' after an abort) to a uart_tx.
module uart_cmd_parser #(
    parameter logic [23:0] ADDR_BASE  = 24'h400000,
    parameter logic [23:0] ADDR_LIMIT = 24'h800000,
    parameter int unsigned TIMEOUT    = 72_000_000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_read,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [23:0] cmd_addr,
    output logic [8:0]  cmd_len,
    output logic        err,
    output logic [1:0]  err_code,
`ifdef UART_CMD_ECHO_EN
    output logic [7:0]  echo_data,
    output logic        echo_write,
    input  logic        echo_ready,
`endif
    output logic        busy
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ADDR, LEN, TERM, ISSUE} state_t;

    state_t         state;
    logic [23:0]    addr_acc;
    logic [7:0]     len_acc;
    logic [2:0]     dcnt;
    logic [TW-1:0]  tcnt;
    logic           echo_ok;
    logic           take;
    logic           hex_ok;
    logic [3:0]     nib;
    logic [1:0]     abort;
    logic [8:0]     len_full;
    logic [24:0]    end_sum;
    logic           win_bad;

`ifdef UART_CMD_ECHO_EN
    logic           q_pend;
    // A pending '?' must reach uart_tx before the next byte is taken.
    assign echo_ok = echo_ready & ~q_pend;
`else
    assign echo_ok = 1'b1;
`endif

    // rx_read is registered, so the cycle carrying the pulse never re-takes the same byte.
    assign take     = rx_valid & ~rx_read & (state != ISSUE) & echo_ok;
    assign busy     = (state != IDLE);
    assign len_full = (len_acc == 8'd0) ? 9'd256 : {1'b0, len_acc};
    assign end_sum  = {1'b0, addr_acc} + {16'd0, len_full};
    assign win_bad  = (addr_acc < ADDR_BASE) || (end_sum > {1'b0, ADDR_LIMIT});

    always_comb begin
        hex_ok = 1'b1;
        nib    = 4'h0;
        if (rx_data >= "0" && rx_data <= "9")
            nib = rx_data[3:0];
        else if ((rx_data >= "A" && rx_data <= "F") || (rx_data >= "a" && rx_data <= "f"))
            nib = rx_data[3:0] + 4'd9;
        else
            hex_ok = 1'b0;
    end

    always_comb begin
        abort = 2'd0;
        case (state)
            IDLE:
                if (take && !(rx_data == "R" || rx_data == "r" || rx_data == 8'h0D ||
                              rx_data == 8'h0A || rx_data == 8'h20))
                    abort = 2'd1;
            ADDR, LEN:
                if (take) begin
                    if (!hex_ok) abort = 2'd1;
                end else if (tcnt == T_LAST) begin
                    abort = 2'd2;
                end
            TERM:
                if (take) begin
                    if (rx_data != 8'h0D) abort = 2'd1;
                    else if (win_bad)     abort = 2'd3;
                end else if (tcnt == T_LAST) begin
                    abort = 2'd2;
                end
            default: abort = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            addr_acc  <= '0;
            len_acc   <= '0;
            dcnt      <= '0;
            tcnt      <= '0;
            rx_read   <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_addr  <= '0;
            cmd_len   <= '0;
            err       <= 1'b0;
            err_code  <= '0;
        end else begin
            rx_read <= take;
            err     <= 1'b0;
            if (take || state == IDLE || state == ISSUE)
                tcnt <= '0;
            else if (tcnt != '1)
                tcnt <= tcnt + TW'(1);

            if (abort != 2'd0) begin
                err      <= 1'b1;
                err_code <= abort;
                state    <= IDLE;
            end else begin
                case (state)
                    IDLE:
                        if (take && (rx_data == "R" || rx_data == "r")) begin
                            state    <= ADDR;
                            addr_acc <= '0;
                            len_acc  <= '0;
                            dcnt     <= '0;
                        end
                    ADDR:
                        if (take) begin
                            addr_acc <= {addr_acc[19:0], nib};
                            if (dcnt == 3'd5) begin
                                dcnt  <= '0;
                                state <= LEN;
                            end else begin
                                dcnt <= dcnt + 3'd1;
                            end
                        end
                    LEN:
                        if (take) begin
                            len_acc <= {len_acc[3:0], nib};
                            if (dcnt == 3'd1) begin
                                dcnt  <= '0;
                                state <= TERM;
                            end else begin
                                dcnt <= dcnt + 3'd1;
                            end
                        end
                    TERM:
                        // Command fields settle one cycle ahead of cmd_valid.
                        if (take) begin
                            cmd_addr <= addr_acc;
                            cmd_len  <= len_full;
                            state    <= ISSUE;
                        end
                    ISSUE:
                        if (!cmd_valid) begin
                            cmd_valid <= 1'b1;
                        end else if (cmd_ready) begin
                            cmd_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef UART_CMD_ECHO_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            echo_data  <= '0;
            echo_write <= 1'b0;
            q_pend     <= 1'b0;
        end else begin
            echo_write <= 1'b0;
            if (take) begin
                echo_write <= 1'b1;
                echo_data  <= rx_data;
            end else if (q_pend && echo_ready) begin
                echo_write <= 1'b1;
                echo_data  <= "?";
            end
            if (abort != 2'd0)
                q_pend <= 1'b1;
            else if (q_pend && echo_ready)
                q_pend <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed scenarios plus random commands scored by a string-level model.
`timescale 1ns/1ps
module tb_uart_cmd_parser;
    localparam int TMO   = 1000;
    localparam int BASE  = 'h400000;
    localparam int LIMIT = 'h800000;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_read;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [23:0] cmd_addr;
    logic [8:0]  cmd_len;
    logic        err;
    logic [1:0]  err_code;
    logic        busy;
`ifdef UART_CMD_ECHO_EN
    logic [7:0]  echo_data;
    logic        echo_write;
    logic        echo_ready = 1'b1;
    logic [7:0]  echo_q[$];
`endif

    int checks  = 0;
    int errors  = 0;
    int err_cnt = 0;

    uart_cmd_parser #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid), .rx_read(rx_read),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .err(err), .err_code(err_code),
`ifdef UART_CMD_ECHO_EN
        .echo_data(echo_data), .echo_write(echo_write), .echo_ready(echo_ready),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (err) err_cnt++;
`ifdef UART_CMD_ECHO_EN
        if (echo_write) echo_q.push_back(echo_data);
`endif
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic string cmd(input string body);
        return $sformatf("%s%c", body, 8'h0D);
    endfunction

    function automatic bit ishex(input logic [7:0] c);
        return (c >= "0" && c <= "9") || (c >= "a" && c <= "f") || (c >= "A" && c <= "F");
    endfunction

    function automatic int hexval(input logic [7:0] c);
        if (c <= "9") return int'(c) - 48;
        if (c >= "a") return int'(c) - 87;
        return int'(c) - 55;
    endfunction

    // Outcome of a fresh command string: code 0 = issued, else error code; last = index of final byte taken.
    function automatic void model(input string s, output int code, output int last,
                                  output int addr, output int len);
        logic [7:0] c;
        code = 0; addr = 0; len = 0; last = 9;
        c = s.getc(0);
        if (c != "R" && c != "r") begin code = 1; last = 0; return; end
        for (int i = 1; i <= 8; i++) begin
            c = s.getc(i);
            if (!ishex(c)) begin code = 1; last = i; return; end
            if (i <= 6) addr = addr * 16 + hexval(c);
            else        len  = len * 16 + hexval(c);
        end
        if (len == 0) len = 256;
        if (s.getc(9) != 8'h0D)                       code = 1;
        else if (addr < BASE || addr + len > LIMIT)   code = 3;
    endfunction

    task automatic send(input logic [7:0] b, output int lat);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rx_read && lat < 200);
        chk("rx_read_seen", rx_read, 1);
        rx_valid = 1'b0;
    endtask

    task automatic run_exp(input string s, input int first, input int last, input int code,
                           input int addr, input int len);
        int e0, lat, k;
        e0 = err_cnt;
        for (int i = first; i <= last; i++) send(s.getc(i), lat);
        k = 0;
        if (code != 0) begin
            while (err_cnt == e0 && k < 5) begin @(negedge clk); k++; end
            chk("err_count", err_cnt - e0, 1);
            chk("err_code", err_code, code);
            chk("idle_after_err", {cmd_valid, busy}, 0);
        end else begin
            while (!cmd_valid && k < 5) begin @(negedge clk); k++; end
            chk("cmd_valid", cmd_valid, 1);
            chk("cmd_addr", cmd_addr, addr);
            chk("cmd_len", cmd_len, len);
            chk("no_err", err_cnt - e0, 0);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            chk("cmd_hold", {cmd_valid, cmd_addr, cmd_len}, {1'b1, addr[23:0], len[8:0]});
            cmd_ready = 1'b1;
            @(negedge clk);
            cmd_ready = 1'b0;
            chk("cmd_released", {cmd_valid, busy}, 0);
        end
    endtask

    initial begin
        int lat, k, e0, code, last, ma, ml, a, l;
        bit flag;
        string s, bad;

        rstn = 1'b1;
        #1 rstn = 1'b0;
        #2 chk("reset_outputs", {rx_read, cmd_valid, err, err_code, busy, cmd_addr, cmd_len}, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // 1: basic command, hold with cmd_ready low, no consumption during ISSUE
        s = cmd("R40001008");
        e0 = err_cnt;
        send(s.getc(0), lat);
        chk("first_latency", lat, 1);
        for (int i = 1; i <= 9; i++) send(s.getc(i), lat);
        k = 0;
        while (!cmd_valid && k < 5) begin @(negedge clk); k++; end
        chk("t1_valid", cmd_valid, 1);
        chk("t1_addr", cmd_addr, 24'h400010);
        chk("t1_len", cmd_len, 8);
        rx_data = " "; rx_valid = 1'b1; flag = 0;
        repeat (5) begin
            @(negedge clk);
            if (rx_read || !cmd_valid || cmd_addr != 24'h400010 || cmd_len != 9'd8) flag = 1;
        end
        chk("t1_stall_stable", flag, 0);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        chk("t1_release", {cmd_valid, busy}, 0);
        k = 0;
        while (!rx_read && k < 5) begin @(negedge clk); k++; end
        chk("t1_space_taken", rx_read, 1);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("t1_space_no_err", err_cnt - e0, 0);

        // 2-4: lowercase/256, bad char recovery, window edges
        run_exp(cmd("r40abCD00"), 0, 9, 0, 'h40ABCD, 256);
        run_exp("R40G", 0, 3, 1, 0, 0);
        run_exp(cmd("R40000001"), 0, 9, 0, 'h400000, 1);
        run_exp(cmd("R3FFFFF01"), 0, 9, 3, 0, 0);
        run_exp(cmd("R7FFFFF02"), 0, 9, 3, 0, 0);
        run_exp(cmd("R7FFFFF01"), 0, 9, 0, 'h7FFFFF, 1);

        // 5: inter-byte timeout
        s = "R4000";
        for (int i = 0; i < 5; i++) send(s.getc(i), lat);
        k = 0;
        while (!err && k < TMO + 10) begin @(negedge clk); k++; end
        chk("timeout_cycles", k, TMO);
        chk("timeout_code", err_code, 2);
        chk("timeout_idle", busy, 0);

        // 6: reset mid-command
        s = "R400";
        for (int i = 0; i < 4; i++) send(s.getc(i), lat);
        e0 = err_cnt;
        @(negedge clk);
        #2 rstn = 1'b0;
        #1 chk("midreset_outputs", {rx_read, cmd_valid, err, err_code, busy, cmd_addr, cmd_len}, 0);
        @(negedge clk);
        rstn = 1'b1;
        chk("midreset_no_err", err_cnt - e0, 0);
`ifdef UART_CMD_ECHO_EN
        echo_q.delete();
        s = cmd("R40000001");
        @(negedge clk);
        echo_ready = 1'b0;
        rx_data = s.getc(0); rx_valid = 1'b1; flag = 0;
        repeat (20) begin @(negedge clk); if (rx_read) flag = 1; end
        chk("echo_stall", flag, 0);
        echo_ready = 1'b1;
        @(negedge clk);
        chk("echo_release", rx_read, 1);
        rx_valid = 1'b0;
        run_exp(s, 1, 9, 0, 'h400000, 1);
        chk("echo_count", echo_q.size(), 10);
        for (int i = 0; i < 10 && i < echo_q.size(); i++) chk("echo_byte", echo_q[i], s.getc(i));
`else
        run_exp(cmd("R40000001"), 0, 9, 0, 'h400000, 1);
`endif

        // random commands
        bad = "GZ/:@gx.";
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       a = BASE + int'($urandom_range(0, 255));
                1:       a = LIMIT - 1 - int'($urandom_range(0, 300));
                2:       a = BASE - 1 - int'($urandom_range(0, 255));
                default: a = int'($urandom_range(0, 'hFFFFFF));
            endcase
            l = int'($urandom_range(0, 255));
            s = $sformatf("%c%06h%02h%c", ($urandom_range(0, 1) == 1) ? 8'h52 : 8'h72,
                          a[23:0], l[7:0], 8'h0D);
            for (int i = 1; i <= 8; i++)
                if (s.getc(i) >= "a" && s.getc(i) <= "f" && $urandom_range(0, 1) == 1)
                    s.putc(i, s.getc(i) - 8'd32);
            if ($urandom_range(0, 5) == 0)
                s.putc(int'($urandom_range(0, 9)), bad.getc(int'($urandom_range(0, 7))));
            model(s, code, last, ma, ml);
            run_exp(s, 0, last, code, ma, ml);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
